// File: rtl/instruction_decode_if.sv
// instruction_decode_if: bundles the IF/ID inputs, the write-back port, the
// fetch stall controls and the ID/EX pipeline register outputs of the decode
// stage. The master side is the surrounding pipeline; the slave side is the
// decode stage itself.
interface instruction_decode_if #(
    parameter int DATA_WIDTH = 32
);
    logic [31:0]           programCounter;
    logic [31:0]           instruction;
    logic                  wbRegWrite;
    logic [4:0]            wbWriteReg;
    logic [DATA_WIDTH-1:0] wbWriteData;
    logic                  pcWrite;
    logic                  ifIdWrite;
    logic [31:0]           programCounterOut;
    logic [DATA_WIDTH-1:0] readData1;
    logic [DATA_WIDTH-1:0] readData2;
    logic [31:0]           immediate;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [4:0]            rd;
    logic                  regWrite;
    logic                  memRead;
    logic                  memWrite;
    logic                  memToReg;
    logic                  aluSrc;
    logic                  regDst;
    logic [1:0]            aluOp;

    modport master (
        output programCounter, instruction, wbRegWrite, wbWriteReg, wbWriteData,
        input  pcWrite, ifIdWrite, programCounterOut, readData1, readData2,
        input  immediate, rs, rt, rd, regWrite, memRead, memWrite, memToReg,
        input  aluSrc, regDst, aluOp
    );

    modport slave (
        input  programCounter, instruction, wbRegWrite, wbWriteReg, wbWriteData,
        output pcWrite, ifIdWrite, programCounterOut, readData1, readData2,
        output immediate, rs, rt, rd, regWrite, memRead, memWrite, memToReg,
        output aluSrc, regDst, aluOp
    );
endinterface

// File: rtl/instruction_decode.sv
// instruction_decode: second pipeline stage. Holds the 32-entry register
// file (written on posedge by write-back), decodes the IF/ID instruction and
// captures everything into the ID/EX register on the negedge.
// Optional feature macro HAZARD_DETECT_EN: when defined, a load-use hazard
// against the instruction in ID/EX stalls fetch for one cycle and loads a
// bubble into the ID/EX control bits. When undefined, fetch never stalls.
module instruction_decode #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input logic                 clk,
    input logic                 resetN,
    instruction_decode_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    logic [DATA_WIDTH-1:0] reg_file [REG_COUNT];

    logic [5:0]            opcode;
    logic [4:0]            rs_addr;
    logic [4:0]            rt_addr;
    logic [4:0]            rd_addr;
    logic [DATA_WIDTH-1:0] rs_value;
    logic [DATA_WIDTH-1:0] rt_value;
    logic [31:0]           imm_ext;

    logic                  dec_reg_write;
    logic                  dec_mem_read;
    logic                  dec_mem_write;
    logic                  dec_mem_to_reg;
    logic                  dec_alu_src;
    logic                  dec_reg_dst;
    logic [1:0]            dec_alu_op;

    logic [31:0]           idex_pc;
    logic [DATA_WIDTH-1:0] idex_rd1;
    logic [DATA_WIDTH-1:0] idex_rd2;
    logic [31:0]           idex_imm;
    logic [4:0]            idex_rs;
    logic [4:0]            idex_rt;
    logic [4:0]            idex_rd;
    logic                  idex_reg_write;
    logic                  idex_mem_read;
    logic                  idex_mem_write;
    logic                  idex_mem_to_reg;
    logic                  idex_alu_src;
    logic                  idex_reg_dst;
    logic [1:0]            idex_alu_op;

    logic                  stall;

    assign opcode  = bus.instruction[31:26];
    assign rs_addr = bus.instruction[25:21];
    assign rt_addr = bus.instruction[20:16];
    assign rd_addr = bus.instruction[15:11];
    assign imm_ext = {{16{bus.instruction[15]}}, bus.instruction[15:0]};

    // Register file write on posedge, so it lands before the negedge capture.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                reg_file[i] <= '0;
            end
        end else if (bus.wbRegWrite && bus.wbWriteReg != 5'd0) begin
            reg_file[bus.wbWriteReg] <= bus.wbWriteData;
        end
    end

    // Combinational register reads; register 0 is forced to zero.
    always_comb begin
        rs_value = (rs_addr == 5'd0) ? '0 : reg_file[rs_addr];
        rt_value = (rt_addr == 5'd0) ? '0 : reg_file[rt_addr];
    end

    // Opcode decode into the control bits; unknown opcodes become a nop.
    always_comb begin
        dec_reg_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_alu_src    = 1'b0;
        dec_reg_dst    = 1'b0;
        dec_alu_op     = 2'b00;
        case (opcode)
            OP_RTYPE: begin
                dec_reg_dst   = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_op    = 2'b10;
            end
            OP_LW: begin
                dec_alu_src    = 1'b1;
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_reg_write  = 1'b1;
            end
            OP_SW: begin
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
            end
            OP_BEQ: begin
                dec_alu_op = 2'b01;
            end
            default: begin
                dec_alu_op = 2'b00;
            end
        endcase
    end

`ifdef HAZARD_DETECT_EN
    // Load-use check against the load sitting in ID/EX; opcode is ignored on purpose.
    always_comb begin
        stall = idex_mem_read && (idex_rt != 5'd0) &&
                ((idex_rt == rs_addr) || (idex_rt == rt_addr));
    end
`else
    assign stall = 1'b0;
`endif

    assign bus.pcWrite   = !stall;
    assign bus.ifIdWrite = !stall;

    // ID/EX register on the same negedge as IF/ID; a stall zeroes only the control bits.
    always_ff @(negedge clk or negedge resetN) begin
        if (!resetN) begin
            idex_pc         <= '0;
            idex_rd1        <= '0;
            idex_rd2        <= '0;
            idex_imm        <= '0;
            idex_rs         <= '0;
            idex_rt         <= '0;
            idex_rd         <= '0;
            idex_reg_write  <= 1'b0;
            idex_mem_read   <= 1'b0;
            idex_mem_write  <= 1'b0;
            idex_mem_to_reg <= 1'b0;
            idex_alu_src    <= 1'b0;
            idex_reg_dst    <= 1'b0;
            idex_alu_op     <= 2'b00;
        end else begin
            idex_pc  <= bus.programCounter;
            idex_rd1 <= rs_value;
            idex_rd2 <= rt_value;
            idex_imm <= imm_ext;
            idex_rs  <= rs_addr;
            idex_rt  <= rt_addr;
            idex_rd  <= rd_addr;
            if (stall) begin
                idex_reg_write  <= 1'b0;
                idex_mem_read   <= 1'b0;
                idex_mem_write  <= 1'b0;
                idex_mem_to_reg <= 1'b0;
                idex_alu_src    <= 1'b0;
                idex_reg_dst    <= 1'b0;
                idex_alu_op     <= 2'b00;
            end else begin
                idex_reg_write  <= dec_reg_write;
                idex_mem_read   <= dec_mem_read;
                idex_mem_write  <= dec_mem_write;
                idex_mem_to_reg <= dec_mem_to_reg;
                idex_alu_src    <= dec_alu_src;
                idex_reg_dst    <= dec_reg_dst;
                idex_alu_op     <= dec_alu_op;
            end
        end
    end

    assign bus.programCounterOut = idex_pc;
    assign bus.readData1         = idex_rd1;
    assign bus.readData2         = idex_rd2;
    assign bus.immediate         = idex_imm;
    assign bus.rs                = idex_rs;
    assign bus.rt                = idex_rt;
    assign bus.rd                = idex_rd;
    assign bus.regWrite          = idex_reg_write;
    assign bus.memRead           = idex_mem_read;
    assign bus.memWrite          = idex_mem_write;
    assign bus.memToReg          = idex_mem_to_reg;
    assign bus.aluSrc            = idex_alu_src;
    assign bus.regDst            = idex_reg_dst;
    assign bus.aluOp             = idex_alu_op;
endmodule
